// File: rtl/frame_dump_pkg.sv
// Types and helpers shared by the frame dump path and the UART pixel loader.
package frame_dump_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;

  typedef logic [8*BYTES_PER_PIXEL-1:0] pixel_t;

  typedef enum logic [2:0] {IDLE, FETCH, SEND, GUARD, WAIT_TX, DONE} dump_state_t;

  // Byte n of a pixel, MSB first: n=0 is [23:16], n=2 is [7:0].
  function automatic logic [7:0] pixel_byte(input pixel_t pix, input logic [1:0] n);
    pixel_t shifted;
    shifted = pix >> (8 * (BYTES_PER_PIXEL - 1 - 32'(n)));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/frame_uart_dumper_if.sv
// BRAM read port plus byte-wide UART transmitter handshake used by the frame dumper.
interface frame_uart_dumper_if #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_busy;

  modport master (
    output ram_addr,
    input  ram_data,
    output tx_data,
    output tx_start,
    input  tx_busy
  );

  modport slave (
    input  ram_addr,
    output ram_data,
    input  tx_data,
    input  tx_start,
    output tx_busy
  );
endinterface

// File: rtl/pixel_byte_serializer.sv
// Holds one latched pixel and walks its bytes MSB first for the UART.
module pixel_byte_serializer
  import frame_dump_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       next_i,
  input  pixel_t     pixel_i,
  output logic       last_o,
  output logic [7:0] tx_data_o
);

  pixel_t     pix_q;
  logic [1:0] byte_idx_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pix_q      <= '0;
      byte_idx_q <= '0;
    end else if (load_i) begin
      pix_q      <= pixel_i;
      byte_idx_q <= '0;
    end else if (next_i && !last_o) begin
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

  always_comb begin
    last_o    = (byte_idx_q == 2'(BYTES_PER_PIXEL - 1));
    tx_data_o = pixel_byte(pix_q, byte_idx_q);
  end

endmodule

// File: rtl/frame_uart_dumper.sv
// Streams a stored frame from a BRAM read port out through a byte UART transmitter,
// pixels in address order, each pixel as R, G, B bytes.
module frame_uart_dumper
  import frame_dump_pkg::*;
#(
  parameter int unsigned PIXEL_COUNT = 512 * 384,
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned ADDR_WIDTH  = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  frame_uart_dumper_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [1:0]            LatLast  = 2'(RAM_LATENCY);

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            lat_q, lat_d;

  logic                  ser_load;
  logic                  ser_next;
  logic                  ser_last;
  logic [7:0]            ser_byte;
  logic [DATA_WIDTH-1:0] ram_word;

  assign ram_word = bus.ram_data;

  pixel_byte_serializer u_serializer (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (ser_load),
    .next_i   (ser_next),
    .pixel_i  (pixel_t'(ram_word)),
    .last_o   (ser_last),
    .tx_data_o(ser_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
    end
  end

  // The address only moves on FETCH entry, so it doubles as the pixel counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          lat_d   = '0;
        end
      end
      FETCH: begin
        if (lat_q == LatLast) state_d = SEND;
        else                  lat_d   = lat_q + 2'd1;
      end
      SEND:  state_d = GUARD;
      // Transmitter may raise busy up to one cycle late, so skip one look at it.
      GUARD: state_d = WAIT_TX;
      WAIT_TX: begin
        if (!bus.tx_busy) begin
          if (abort) begin
            state_d = IDLE;
          end else if (!ser_last) begin
            state_d = SEND;
          end else if (addr_q == LastAddr) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            addr_d  = addr_q + 1'b1;
            lat_d   = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ser_load     = (state_q == FETCH) && (lat_q == LatLast);
    ser_next     = (state_q == WAIT_TX) && !bus.tx_busy && !abort && !ser_last;
    bus.ram_addr = addr_q;
    bus.tx_data  = ser_byte;
    bus.tx_start = (state_q == SEND);
    busy         = (state_q != IDLE) && (state_q != DONE);
    done         = (state_q == DONE);
  end

endmodule

// File: tb/tb_frame_uart_dumper.sv
// Bench for frame_uart_dumper: two instances (RAM latency 1 and 3) against a BRAM model,
// a UART model and a byte-stream reference built from the frame contents.
module tb_frame_uart_dumper;

  localparam int unsigned NPIX = 4;
  localparam int unsigned AW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        start, abort, stall;
  logic [1:0]        busy_w, done_w, tx_start_w, tx_busy_w;
  logic [AW-1:0]     ram_addr_w [2];
  logic [7:0]        tx_data_w  [2];
  logic [23:0]       ram_data_w [2];
  logic [23:0]       mem [NPIX];
  logic [23:0]       pipe [2][3];
  int                busy_cnt [2];
  int                busy_len;

  logic [7:0]        rx0 [$];
  logic [7:0]        rx1 [$];
  logic [7:0]        expq [$];
  int                start_cnt [2];
  int                done_cnt [2];
  int                proto_err [2];
  int                n_checks;
  int                n_fail;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    frame_uart_dumper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(24)) bus ();
    frame_uart_dumper #(
      .PIXEL_COUNT(NPIX),
      .DATA_WIDTH (24),
      .ADDR_WIDTH (AW),
      .RAM_LATENCY((g == 0) ? 1 : 3)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start[g]),
      .abort(abort[g]),
      .bus  (bus),
      .busy (busy_w[g]),
      .done (done_w[g])
    );
    assign bus.ram_data  = ram_data_w[g];
    assign bus.tx_busy   = tx_busy_w[g];
    assign ram_addr_w[g] = bus.ram_addr;
    assign tx_data_w[g]  = bus.tx_data;
    assign tx_start_w[g] = bus.tx_start;
  end

  // BRAM models: one and three register stages; UART: busy for busy_len cycles after tx_start.
  assign ram_data_w[0] = pipe[0][0];
  assign ram_data_w[1] = pipe[1][2];
  assign tx_busy_w[0]  = (busy_cnt[0] != 0) || stall[0];
  assign tx_busy_w[1]  = (busy_cnt[1] != 0) || stall[1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= mem[ram_addr_w[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
      if (reset)                  busy_cnt[k] <= 0;
      else if (tx_start_w[k])     busy_cnt[k] <= busy_len;
      else if (busy_cnt[k] != 0)  busy_cnt[k] <= busy_cnt[k] - 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start_w[0]) rx0.push_back(tx_data_w[0]);
      if (tx_start_w[1]) rx1.push_back(tx_data_w[1]);
      for (int k = 0; k < 2; k++) begin
        if (tx_start_w[k]) begin
          start_cnt[k]++;
          if (tx_busy_w[k]) proto_err[k]++;
        end
        if (done_w[k]) begin
          done_cnt[k]++;
          if (busy_w[k]) proto_err[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    rx0.delete();
    rx1.delete();
    for (int k = 0; k < 2; k++) begin
      start_cnt[k] = 0;
      done_cnt[k]  = 0;
      proto_err[k] = 0;
    end
  endtask

  // Reference stream: every pixel in address order, R then G then B.
  task automatic build_expected();
    logic [23:0] w;
    expq.delete();
    for (int p = 0; p < NPIX; p++)
      for (int b = 0; b < 3; b++) begin
        w = mem[p] >> (16 - 8 * b);
        expq.push_back(w[7:0]);
      end
  endtask

  task automatic check_stream(input int k, input int n, input string name);
    logic [7:0] got [$];
    int bad;
    if (k == 0) got = rx0;
    else        got = rx1;
    check({name, "_count"}, got.size(), n);
    bad = 0;
    for (int i = 0; i < n; i++)
      if (i >= got.size() || got[i] !== expq[i]) bad++;
    check({name, "_bytes_wrong"}, bad, 0);
  endtask

  task automatic wait_done(input int k, input string name);
    int c = 0;
    while (done_cnt[k] == 0 && c < 3000) begin
      tick();
      c++;
    end
    n_checks++;
    if (done_cnt[k] == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: done count %0d after %0d cycles, required 1", name, done_cnt[k], c);
    end
  endtask

  task automatic wait_starts(input int k, input int n, input string name);
    int c = 0;
    while (start_cnt[k] < n && c < 1000) begin
      tick();
      c++;
    end
    n_checks++;
    if (start_cnt[k] < n) begin
      n_fail++;
      $display("FAIL %s_timeout: tx_start count %0d, required %0d", name, start_cnt[k], n);
    end
  endtask

  task automatic fill_ramp(input logic [23:0] base);
    for (int p = 0; p < NPIX; p++) mem[p] = base + 24'(p);
  endtask

  task automatic pulse(input logic [1:0] which);
    start = which;
    tick();
    start = 2'b00;
  endtask

  typedef struct {
    logic [23:0] base;
    int          blen;
    logic [7:0]  first;
    logic [7:0]  last;
    int          nbytes;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int drift;
    int c;
    logic [7:0] held;

    vecs[0] = '{24'h112233, 10, 8'h11, 8'h36, 12};
    vecs[1] = '{24'h000000, 3,  8'h00, 8'h03, 12};
    vecs[2] = '{24'hFFFFFE, 1,  8'hFF, 8'h01, 12};
    vecs[3] = '{24'hABCDEF, 25, 8'hAB, 8'hF2, 12};

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 2'b00;
    abort    = 2'b00;
    stall    = 2'b00;
    busy_len = 10;
    fill_ramp(24'h112233);
    clear_logs();
    repeat (3) tick();

    check("rst_ram_addr", 32'(ram_addr_w[0]), 0);
    check("rst_tx_data",  32'(tx_data_w[0]),  0);
    check("rst_tx_start", 32'(tx_start_w[0]), 0);
    check("rst_busy",     32'(busy_w[0]),     0);
    check("rst_done",     32'(done_w[0]),     0);
    reset = 1'b0;
    tick();

    // Full dumps on both latency variants.
    for (int i = 0; i < 4; i++) begin
      fill_ramp(vecs[i].base);
      busy_len = vecs[i].blen;
      clear_logs();
      build_expected();
      pulse(2'b11);
      wait_done(0, $sformatf("vec%0d_lat1", i));
      wait_done(1, $sformatf("vec%0d_lat3", i));
      repeat (5) tick();
      check($sformatf("vec%0d_first", i), 32'((rx0.size() > 0) ? rx0[0] : 8'hxx), 32'(vecs[i].first));
      check($sformatf("vec%0d_last", i),
            32'((rx0.size() == 12) ? rx0[11] : 8'hxx), 32'(vecs[i].last));
      check_stream(0, vecs[i].nbytes, $sformatf("vec%0d_lat1", i));
      check_stream(1, vecs[i].nbytes, $sformatf("vec%0d_lat3", i));
      check($sformatf("vec%0d_done_lat1", i), done_cnt[0], 1);
      check($sformatf("vec%0d_done_lat3", i), done_cnt[1], 1);
      check($sformatf("vec%0d_proto", i), proto_err[0] + proto_err[1], 0);
      check($sformatf("vec%0d_busy_after", i), 32'(busy_w), 0);
    end

    // Random frames and transmitter speeds.
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < NPIX; p++) mem[p] = 24'($urandom);
      busy_len = $urandom_range(1, 15);
      clear_logs();
      build_expected();
      pulse(2'b11);
      wait_done(0, $sformatf("rnd%0d_lat1", i));
      wait_done(1, $sformatf("rnd%0d_lat3", i));
      repeat (5) tick();
      check_stream(0, 12, $sformatf("rnd%0d_lat1", i));
      check_stream(1, 12, $sformatf("rnd%0d_lat3", i));
      check($sformatf("rnd%0d_proto", i), proto_err[0] + proto_err[1], 0);
    end

    // Transmitter stalls on the third byte.
    fill_ramp(24'h112233);
    busy_len = 10;
    clear_logs();
    build_expected();
    pulse(2'b01);
    wait_starts(0, 3, "stall_reach");
    stall[0] = 1'b1;
    held  = tx_data_w[0];
    drift = 0;
    check("stall_byte", 32'(held), 32'h33);
    repeat (500) begin
      tick();
      if (tx_data_w[0] !== held) drift++;
    end
    check("stall_no_extra_start", start_cnt[0], 3);
    check("stall_data_stable", drift, 0);
    check("stall_busy_held", 32'(busy_w[0]), 1);
    stall[0] = 1'b0;
    wait_done(0, "stall");
    repeat (5) tick();
    check_stream(0, 12, "stall");
    check("stall_done", done_cnt[0], 1);

    // Abort during pixel 1 byte 0: that byte finishes, nothing after it.
    clear_logs();
    pulse(2'b01);
    wait_starts(0, 4, "abort_reach");
    abort[0] = 1'b1;
    c = 0;
    while (busy_w[0] && c < 200) begin
      tick();
      c++;
    end
    abort[0] = 1'b0;
    repeat (30) tick();
    check_stream(0, 4, "abort");
    check("abort_busy", 32'(busy_w[0]), 0);
    check("abort_no_done", done_cnt[0], 0);

    // Reset in the middle of pixel 2, then a fresh dump from address 0.
    clear_logs();
    pulse(2'b01);
    wait_starts(0, 8, "rstmid_reach");
    reset = 1'b1;
    tick();
    check("rstmid_ram_addr", 32'(ram_addr_w[0]), 0);
    check("rstmid_tx_data",  32'(tx_data_w[0]),  0);
    check("rstmid_tx_start", 32'(tx_start_w[0]), 0);
    check("rstmid_busy",     32'(busy_w[0]),     0);
    check("rstmid_done",     32'(done_w[0]),     0);
    reset = 1'b0;
    tick();
    clear_logs();
    pulse(2'b01);
    wait_done(0, "rstmid_redump");
    repeat (5) tick();
    check_stream(0, 12, "rstmid_redump");

    // Extra starts while busy and in the done cycle are all ignored.
    clear_logs();
    pulse(2'b01);
    for (int j = 0; j < 5; j++) begin
      repeat (20) tick();
      pulse(2'b01);
    end
    c = 0;
    while (!done_w[0] && c < 3000) begin
      tick();
      c++;
    end
    check("multi_done_seen", 32'(done_w[0]), 1);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (300) tick();
    check_stream(0, 12, "multi_start");
    check("multi_done_cnt", done_cnt[0], 1);
    check("multi_busy", 32'(busy_w[0]), 0);
    check("multi_proto", proto_err[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
